// File: rtl/pedda_8b10b_pkg.sv
// Shared 8b10b symbol codes and framer state encoding.
// Used by the framer, the encoder side and the receiver blocks.
package pedda_8b10b_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOP   = 8'hFB;
  localparam logic [7:0] K_EOP   = 8'hFD;
  localparam logic [7:0] K_ABORT = 8'hFE;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_PAYLOAD,
    ST_EOP,
    ST_ABORT,
    ST_DRAIN
  } fr_state_e;

endpackage

// File: rtl/pkt_framer_if.sv
// Upstream byte stream into the packet framer.
// Valid/ready handshake with an end-of-packet marker.
interface pkt_framer_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/pkt_framer.sv
// Packet framer: wraps upstream bytes in SOP/EOP K-codes for 8b10b.
// One registered symbol per cycle; commas fill every idle slot.
module pkt_framer
  import pedda_8b10b_pkg::*;
#(
  parameter int SYNC_LEN = 16,
  parameter int MAX_LEN  = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  pkt_framer_if.slave s,
  output logic       k_out,
  output logic [7:0] data_out,
  output logic       len_err
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_LEN);
  localparam logic [SW-1:0] SLST = SW'(SYNC_LEN - 1);

  fr_state_e     r_state, w_state;
  logic [SW-1:0] r_sync, w_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_k, w_k;
  logic [7:0]    r_data, w_data;
  logic          r_err, w_err;
  logic          w_ready;
  logic [CW-1:0] w_inc;
  logic          w_comma;

  assign w_ready = (r_state == ST_PAYLOAD)
                || (r_state == ST_DRAIN);
  assign s.s_ready = w_ready;
  assign w_inc = r_cnt + CW'(1);
  // SOP only after a comma, so EOP is never followed directly by SOP
  assign w_comma = r_k && (r_data == K_COMMA);

  always_comb begin
    w_state = r_state;
    w_sync  = r_sync;
    w_cnt   = r_cnt;
    w_k     = 1'b1;
    w_data  = K_COMMA;
    w_err   = 1'b0;
    unique case (r_state)
      ST_SYNC: begin
        if (r_sync == SLST) begin
          w_sync  = '0;
          w_state = ST_IDLE;
        end else begin
          w_sync = r_sync + SW'(1);
        end
      end
      ST_IDLE: begin
        if (s.s_valid && w_comma) begin
          w_data  = K_SOP;
          w_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (s.s_valid) begin
          w_k    = 1'b0;
          w_data = s.s_data;
          w_cnt  = w_inc;
          if (s.s_last)
            w_state = ST_EOP;
          else if (w_inc == MAXC)
            w_state = ST_ABORT;
        end
      end
      ST_EOP: begin
        w_data  = K_EOP;
        w_cnt   = '0;
        w_state = ST_IDLE;
      end
      ST_ABORT: begin
        w_data  = K_ABORT;
        w_err   = 1'b1;
        w_cnt   = '0;
        w_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (s.s_valid && s.s_last)
          w_state = ST_IDLE;
      end
      default: w_state = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SYNC;
      r_sync  <= '0;
      r_cnt   <= '0;
      r_k     <= 1'b1;
      r_data  <= K_COMMA;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sync  <= w_sync;
      r_cnt   <= w_cnt;
      r_k     <= w_k;
      r_data  <= w_data;
      r_err   <= w_err;
    end
  end

  assign k_out    = r_k;
  assign data_out = r_data;
  assign len_err  = r_err;

endmodule

// File: tb/tb_pkt_framer.sv
// Self-checking bench for pkt_framer: directed vector table,
// reset corner cases and random traffic against a queue-based model.
module tb_pkt_framer;

  localparam int SYNC_LEN = 16;
  localparam int MAX_LEN  = 4;
  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] FB = 8'hFB;
  localparam logic [7:0] FD = 8'hFD;
  localparam logic [7:0] FE = 8'hFE;

  logic       clk;
  logic       rst_n;
  logic       k_out;
  logic [7:0] data_out;
  logic       len_err;

  pkt_framer_if bif ();

  pkt_framer #(
    .SYNC_LEN(SYNC_LEN),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (bif),
    .k_out   (k_out),
    .data_out(data_out),
    .len_err (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: packet-level view with a queue of pending trailers
  typedef enum int { M_IDLE, M_PKT, M_DROP } mmode_e;
  int         m_sync;
  mmode_e     m_mode;
  int         m_n;
  logic [7:0] m_pend[$];
  logic       m_lk;
  logic [7:0] m_ld;
  logic       e_k;
  logic [7:0] e_d;
  logic       e_e;
  logic       e_rdy;

  task automatic model_reset();
    m_sync = SYNC_LEN;
    m_mode = M_IDLE;
    m_n    = 0;
    m_pend.delete();
    m_lk   = 1'b1;
    m_ld   = BC;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d,
                            input logic l);
    logic [7:0] sym;
    e_rdy = (m_sync == 0) && (m_pend.size() == 0)
         && (m_mode != M_IDLE);
    e_k = 1'b1;
    e_d = BC;
    e_e = 1'b0;
    if (m_sync > 0) begin
      m_sync--;
    end else if (m_pend.size() != 0) begin
      sym = m_pend.pop_front();
      e_d = sym;
      e_e = (sym == FE);
    end else if (m_mode == M_IDLE) begin
      if (v && m_lk && m_ld == BC) begin
        e_d    = FB;
        m_mode = M_PKT;
        m_n    = 0;
      end
    end else if (m_mode == M_PKT) begin
      if (v) begin
        e_k = 1'b0;
        e_d = d;
        m_n++;
        if (l) begin
          m_pend.push_back(FD);
          m_mode = M_IDLE;
        end else if (m_n == MAX_LEN) begin
          m_pend.push_back(FE);
          m_mode = M_DROP;
        end
      end
    end else begin
      if (v && l) m_mode = M_IDLE;
    end
    m_lk = e_k;
    m_ld = e_d;
  endtask

  // One clock: drive, check ready, advance model, check symbol
  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic l);
    bif.s_valid = v;
    bif.s_data  = d;
    bif.s_last  = l;
    @(negedge clk);
    model_step(v, d, l);
    chk("s_ready", int'(bif.s_ready), int'(e_rdy));
    @(posedge clk);
    #1;
    chk("k_out", int'(k_out), int'(e_k));
    chk("data_out", int'(data_out), int'(e_d));
    chk("len_err", int'(len_err), int'(e_e));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       ek;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic l,
                     input logic ek, input logic [7:0] ed,
                     input logic ee);
    vec_t x;
    x.v = v; x.d = d; x.l = l;
    x.ek = ek; x.ed = ed; x.ee = ee;
    tbl.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.s_valid = 1'b0;
    bif.s_data  = 8'h00;
    bif.s_last  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_k", int'(k_out), 1);
    chk("rst_data", int'(data_out), int'(BC));
    chk("rst_err", int'(len_err), 0);
    chk("rst_ready", int'(bif.s_ready), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic sop_count(input string nm);
    int pos;
    pos = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 8'h5A, 1'b1);
      if (k_out && data_out == FB) begin
        pos = i;
        break;
      end
    end
    chk(nm, pos, SYNC_LEN + 1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    do_reset();

    for (int i = 0; i < SYNC_LEN + 2; i++)
      cyc(1'b0, 8'h00, 1'b0);

    // 3-byte packet, back-to-back single-byte packet
    add(1, 8'h11, 0, 1, FB, 0);
    add(1, 8'h11, 0, 0, 8'h11, 0);
    add(1, 8'h22, 0, 0, 8'h22, 0);
    add(1, 8'h33, 1, 0, 8'h33, 0);
    add(1, 8'h44, 0, 1, FD, 0);
    add(1, 8'h44, 0, 1, BC, 0);
    add(1, 8'h44, 1, 1, FB, 0);
    add(1, 8'h44, 1, 0, 8'h44, 0);
    add(0, 8'h00, 0, 1, FD, 0);
    add(0, 8'h00, 0, 1, BC, 0);
    // underrun mid-packet
    add(1, 8'h11, 0, 1, FB, 0);
    add(1, 8'h11, 0, 0, 8'h11, 0);
    add(1, 8'h22, 0, 0, 8'h22, 0);
    add(0, 8'h00, 0, 1, BC, 0);
    add(0, 8'h00, 0, 1, BC, 0);
    add(1, 8'h33, 1, 0, 8'h33, 0);
    add(0, 8'h00, 0, 1, FD, 0);
    add(0, 8'h00, 0, 1, BC, 0);
    // exactly MAX_LEN bytes terminates normally
    add(1, 8'hA1, 0, 1, FB, 0);
    add(1, 8'hA1, 0, 0, 8'hA1, 0);
    add(1, 8'hA2, 0, 0, 8'hA2, 0);
    add(1, 8'hA3, 0, 0, 8'hA3, 0);
    add(1, 8'hA4, 1, 0, 8'hA4, 0);
    add(0, 8'h00, 0, 1, FD, 0);
    add(0, 8'h00, 0, 1, BC, 0);
    // over-length packet aborts and drains
    add(1, 8'hB1, 0, 1, FB, 0);
    add(1, 8'hB1, 0, 0, 8'hB1, 0);
    add(1, 8'hB2, 0, 0, 8'hB2, 0);
    add(1, 8'hB3, 0, 0, 8'hB3, 0);
    add(1, 8'hB4, 0, 0, 8'hB4, 0);
    add(1, 8'hB5, 0, 1, FE, 1);
    add(1, 8'hB5, 0, 1, BC, 0);
    add(1, 8'hB6, 1, 1, BC, 0);
    add(0, 8'h00, 0, 1, BC, 0);
    add(1, 8'hC1, 1, 1, FB, 0);
    add(1, 8'hC1, 1, 0, 8'hC1, 0);
    add(0, 8'h00, 0, 1, FD, 0);
    add(0, 8'h00, 0, 1, BC, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l);
      chk($sformatf("tbl%0d_k", i), int'(k_out), int'(tbl[i].ek));
      chk($sformatf("tbl%0d_d", i), int'(data_out), int'(tbl[i].ed));
      chk($sformatf("tbl%0d_e", i), int'(len_err), int'(tbl[i].ee));
    end

    // Sync length after release with traffic waiting
    do_reset();
    sop_count("sop_after_sync");
    cyc(1'b1, 8'h5A, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    // Asynchronous reset during the second payload byte
    cyc(1'b1, 8'h61, 1'b0);
    cyc(1'b1, 8'h61, 1'b0);
    cyc(1'b1, 8'h62, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_k", int'(k_out), 1);
    chk("arst_data", int'(data_out), int'(BC));
    chk("arst_err", int'(len_err), 0);
    chk("arst_ready", int'(bif.s_ready), 0);
    do_reset();
    sop_count("sop_after_arst");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic       v;
      logic [7:0] d;
      logic       l;
      v = ($urandom_range(0, 9) < 7);
      d = 8'($urandom);
      l = ($urandom_range(0, 3) == 0);
      cyc(v, d, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
